// File: rtl/keypad_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_decoder
// Description : Receive side of a 4x4 keypad scan. Registers the active-low
//               one-hot column strobe and row returns, debounces each of the
//               16 keys, keeps a debounced key map and reports key events
//               through a registered valid/ready output slot.
//               Optional release events: define KEYPAD_RELEASE_EVENT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_decoder #(
   parameter int unsigned DEBOUNCE_SCANS = 4,     // legal 1..255
   parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  column,
   input  logic [3:0]  row,
   output logic [15:0] key_down,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ready,
   output logic        key_release
);

   localparam int         NUM_KEYS     = 16;
   // The counter reaching this value on a disagreeing sample flips the key
   localparam logic [7:0] C_LAST_COUNT = 8'(DEBOUNCE_SCANS - 1);

   logic [3:0]  column_d, column_q;
   logic [3:0]  row_d, row_q;
   logic        col_vld;
   logic [1:0]  col_idx;
   logic [3:0]  raw_press;
   logic [7:0]  cnt_d [NUM_KEYS];
   logic [7:0]  cnt_q [NUM_KEYS];
   logic [15:0] key_down_d, key_down_q;
   logic [15:0] rise, fall;
   logic [15:0] press_pend_d, press_pend_q;
   logic [15:0] rel_pend_v;
   logic [15:0] grant_oh;
   logic [3:0]  grant_code;
   logic        grant_rel, grant_any;
   logic        slot_load;
   logic        key_valid_d, key_valid_q;
   logic [3:0]  key_code_d, key_code_q;

   // Stage 0: the only path from the scanner pins
   always_comb begin
      column_d = column;
      row_d    = row;
   end

   // Stage 0 registers; column resets to "nothing strobed"
   always_ff @(posedge clk) begin
      if (reset) begin
         column_q <= 4'b1111;
         row_q    <= 4'b0000;
      end else begin
         column_q <= column_d;
         row_q    <= row_d;
      end
   end

   // Column decode: exactly one low bit is a usable sample
   always_comb begin
      col_vld = 1'b1;
      col_idx = 2'd0;
      case (column_q)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_vld = 1'b0;
      endcase
   end

   // Row returns normalised to 1 = pressed
   always_comb begin
      raw_press = ROW_ACTIVE_LOW ? ~row_q : row_q;
   end

   // Stage 1: debounce the four keys of the strobed column
   always_comb begin
      key_down_d = key_down_q;
      rise       = '0;
      fall       = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (col_vld && ((i / 4) == int'(col_idx))) begin
            if (raw_press[i % 4] == key_down_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == C_LAST_COUNT) begin
               cnt_d[i]      = '0;
               key_down_d[i] = ~key_down_q[i];
               rise[i]       = ~key_down_q[i];
               fall[i]       = key_down_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         key_down_q <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         key_down_q <= key_down_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Arbiter: lowest key index with anything pending; press before release
   always_comb begin
      grant_oh   = '0;
      grant_code = '0;
      grant_rel  = 1'b0;
      grant_any  = 1'b0;
      // Descending scan so the last hit (lowest index) wins
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press_pend_q[i] || rel_pend_v[i]) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_code  = 4'(i);
            grant_rel   = ~press_pend_q[i];
            grant_any   = 1'b1;
         end
      end
   end

   // Output slot refills when empty or being consumed; new flips are merged
   // after the clear so a same-edge set stays pending for the next cycle
   always_comb begin
      slot_load    = ~key_valid_q | key_ready;
      key_valid_d  = slot_load ? grant_any : key_valid_q;
      key_code_d   = (slot_load && grant_any) ? grant_code : key_code_q;
      press_pend_d = (press_pend_q & ~((slot_load && !grant_rel) ? grant_oh : 16'h0000)) | rise;
   end

   // Output slot and press pending registers
   always_ff @(posedge clk) begin
      if (reset) begin
         key_valid_q  <= 1'b0;
         key_code_q   <= 4'd0;
         press_pend_q <= '0;
      end else begin
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         press_pend_q <= press_pend_d;
      end
   end

`ifdef KEYPAD_RELEASE_EVENT_EN
   logic [15:0] rel_pend_d, rel_pend_q;
   logic        key_release_d, key_release_q;

   // Release pending bits and event type, same load/merge rule as presses
   always_comb begin
      rel_pend_d    = (rel_pend_q & ~((slot_load && grant_rel) ? grant_oh : 16'h0000)) | fall;
      key_release_d = (slot_load && grant_any) ? grant_rel : key_release_q;
   end

   // Release pending and event type registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rel_pend_q    <= '0;
         key_release_q <= 1'b0;
      end else begin
         rel_pend_q    <= rel_pend_d;
         key_release_q <= key_release_d;
      end
   end

   assign rel_pend_v  = rel_pend_q;
   assign key_release = key_release_q;
`else
   // Releases only change the key map in this build
   logic unused_fall;
   assign unused_fall = ^fall;
   assign rel_pend_v  = '0;
   assign key_release = 1'b0;
`endif

   assign key_down  = key_down_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_decoder
// Description : Self-checking bench for keypad_scan_decoder: directed
//               scenarios plus randomized scanning against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_decoder;

   localparam int DEB    = 4;
   localparam bit ROW_AL = 1'b1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  column = 4'hF;
   logic [3:0]  row = 4'hF;
   logic        key_ready = 1'b0;
   logic [15:0] key_down;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_release;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   keypad_scan_decoder #(
      .DEBOUNCE_SCANS (DEB),
      .ROW_ACTIVE_LOW (ROW_AL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .column      (column),
      .row         (row),
      .key_down    (key_down),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .key_release (key_release)
   );

   // Behavioural model state
   bit         m_down [16];
   int         m_cnt  [16];
   bit         m_press[16];
   bit         m_relp [16];
   bit         m_valid;
   logic [3:0] m_code;
   bit         m_rel;
   logic [3:0] m_col;
   logic [3:0] m_row;

   task automatic model_reset();
      for (int k = 0; k < 16; k++) begin
         m_down[k] = 0; m_cnt[k] = 0; m_press[k] = 0; m_relp[k] = 0;
      end
      m_valid = 0; m_code = 4'd0; m_rel = 0;
      m_col = 4'hF; m_row = 4'h0;
   endtask

   // One clock edge of the specified behaviour
   task automatic model_step(input logic [3:0] c, input logic [3:0] r, input logic rdy);
      int ci;
      int k;
      bit p;
      if (!m_valid || rdy) begin
         m_valid = 0;
         for (int j = 0; j < 16; j++) begin
            if (!m_valid && m_press[j]) begin
               m_valid = 1; m_code = 4'(j); m_rel = 0; m_press[j] = 0;
            end else if (!m_valid && m_relp[j]) begin
               m_valid = 1; m_code = 4'(j); m_rel = 1; m_relp[j] = 0;
            end
         end
      end
      ci = -1;
      if ($countones(~m_col) == 1) begin
         for (int j = 0; j < 4; j++) if (!m_col[j]) ci = j;
      end
      if (ci >= 0) begin
         for (int j = 0; j < 4; j++) begin
            k = ci * 4 + j;
            p = ROW_AL ? !m_row[j] : m_row[j];
            if (p == m_down[k]) begin
               m_cnt[k] = 0;
            end else begin
               m_cnt[k] = m_cnt[k] + 1;
               if (m_cnt[k] == DEB) begin
                  m_cnt[k]  = 0;
                  m_down[k] = p;
                  if (p) m_press[k] = 1;
`ifdef KEYPAD_RELEASE_EVENT_EN
                  else m_relp[k] = 1;
`endif
               end
            end
         end
      end
      m_col = c;
      m_row = r;
   endtask

   function automatic logic [15:0] model_down_vec();
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = m_down[k];
      return v;
   endfunction

   // Drive one cycle, advance the model at the edge, return at the negedge
   task automatic cyc(input logic [3:0] c, input logic [3:0] r, input logic rdy);
      column = c; row = r; key_ready = rdy;
      @(posedge clk);
      model_step(c, r, rdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; column = 4'hF; row = 4'hF; key_ready = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [3:0] rot_col(input int i);
      logic [3:0] c;
      c = 4'hF;
      c[i % 4] = 1'b0;
      return c;
   endfunction

   task automatic test_reset();
      do_reset();
      n_checks++; if (key_down !== 16'h0) $display("FAIL reset_key_down got %h want 0000", key_down); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid got %b want 0", key_valid); else n_pass++;
      n_checks++; if (key_code !== 4'd0) $display("FAIL reset_key_code got %0d want 0", key_code); else n_pass++;
      n_checks++; if (key_release !== 1'b0) $display("FAIL reset_key_release got %b want 0", key_release); else n_pass++;
   endtask

   task automatic test_idle_rotation();
      do_reset();
      for (int i = 0; i < 64; i++) begin
         cyc(rot_col(i), 4'b1111, 1'($urandom_range(1)));
         n_checks++; if (key_valid !== 1'b0) $display("FAIL idle_valid cyc %0d got %b want 0", i, key_valid); else n_pass++;
      end
      n_checks++; if (key_down !== 16'h0) $display("FAIL idle_key_down got %h want 0000", key_down); else n_pass++;
   endtask

   task automatic test_key6_press();
      logic [3:0] r;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         r = (i % 4 == 1) ? 4'b1011 : 4'b1111;
         cyc(rot_col(i), r, i == 20);
         n_checks++;
         if (key_down[6] !== (i >= 14)) $display("FAIL key6_down cyc %0d got %b want %b", i, key_down[6], i >= 14);
         else n_pass++;
         n_checks++;
         if (key_valid !== (i >= 15 && i <= 19)) $display("FAIL key6_valid cyc %0d got %b want %b", i, key_valid, (i >= 15 && i <= 19));
         else n_pass++;
         if (i >= 15 && i <= 19) begin
            n_checks++;
            if (key_code !== 4'd6 || key_release !== 1'b0)
               $display("FAIL key6_event cyc %0d got code %0d rel %b want code 6 rel 0", i, key_code, key_release);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_event();
      logic [3:0] r;
      do_reset();
      // keys 1 and 6 pressed; hold the first event, leaving key 6 pending
      for (int i = 0; i < 16; i++) begin
         r = (i % 4 == 0) ? 4'b1101 : ((i % 4 == 1) ? 4'b1011 : 4'b1111);
         cyc(rot_col(i), r, 1'b0);
      end
      n_checks++;
      if (key_valid !== 1'b1 || key_code !== 4'd1) $display("FAIL midreset_pre got valid %b code %0d want valid 1 code 1", key_valid, key_code);
      else n_pass++;
      do_reset();
      n_checks++;
      if (key_valid !== 1'b0 || key_down !== 16'h0) $display("FAIL midreset_post got valid %b down %h want 0 0000", key_valid, key_down);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         cyc(rot_col(i), 4'b1111, 1'b1);
         n_checks++; if (key_valid !== 1'b0) $display("FAIL midreset_dropped cyc %0d got valid %b want 0", i, key_valid); else n_pass++;
      end
   endtask

   task automatic test_bounce();
      logic [3:0] r;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         r = (i == 3) ? 4'b1111 : 4'b1011;
         cyc(4'b1101, r, 1'b1);
         n_checks++;
         if (key_down[6] !== (i >= 8)) $display("FAIL bounce_down cyc %0d got %b want %b", i, key_down[6], i >= 8);
         else n_pass++;
         n_checks++;
         if (key_valid !== (i == 9)) $display("FAIL bounce_valid cyc %0d got %b want %b", i, key_valid, i == 9);
         else n_pass++;
         if (i == 9) begin
            n_checks++; if (key_code !== 4'd6) $display("FAIL bounce_code got %0d want 6", key_code); else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] r;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         r = (i % 4 == 0) ? 4'b1101 : ((i % 4 == 3) ? 4'b1100 : 4'b1111);
         cyc(rot_col(i), r, i >= 20);
         if (i >= 14 && i <= 19) begin
            n_checks++;
            if (key_valid !== 1'b1 || key_code !== 4'd1) $display("FAIL b2b_hold cyc %0d got valid %b code %0d want 1 1", i, key_valid, key_code);
            else n_pass++;
         end
         if (i == 20 || i == 21) begin
            n_checks++;
            if (key_valid !== 1'b1 || key_code !== ((i == 20) ? 4'd12 : 4'd13))
               $display("FAIL b2b_seq cyc %0d got valid %b code %0d want 1 %0d", i, key_valid, key_code, (i == 20) ? 12 : 13);
            else n_pass++;
         end
         if (i >= 22) begin
            n_checks++; if (key_valid !== 1'b0) $display("FAIL b2b_empty cyc %0d got %b want 0", i, key_valid); else n_pass++;
         end
      end
      n_checks++; if (key_down !== 16'h3002) $display("FAIL b2b_down got %h want 3002", key_down); else n_pass++;
   endtask

   // Follows test_back_to_back: keys 1, 12, 13 are down
   task automatic test_invalid_columns();
      for (int i = 0; i < 20; i++) begin
         cyc((i % 2 == 0) ? 4'b0000 : 4'b1100, 4'b0000, 1'b1);
         n_checks++;
         if (key_down !== 16'h3002 || key_valid !== 1'b0)
            $display("FAIL invalid_col cyc %0d got down %h valid %b want 3002 0", i, key_down, key_valid);
         else n_pass++;
      end
   endtask

   task automatic test_release();
      int events;
      events = 0;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         cyc(4'b0111, (i < 8) ? 4'b0111 : 4'b1111, 1'b1);
         if (key_valid) events++;
         if (i == 5) begin
            n_checks++;
            if (key_valid !== 1'b1 || key_code !== 4'd15 || key_release !== 1'b0)
               $display("FAIL rel_press got valid %b code %0d rel %b want 1 15 0", key_valid, key_code, key_release);
            else n_pass++;
         end
         if (i == 11 || i == 12) begin
            n_checks++;
            if (key_down[15] !== (i == 11)) $display("FAIL rel_down cyc %0d got %b want %b", i, key_down[15], i == 11);
            else n_pass++;
         end
`ifdef KEYPAD_RELEASE_EVENT_EN
         if (i == 13) begin
            n_checks++;
            if (key_valid !== 1'b1 || key_code !== 4'd15 || key_release !== 1'b1)
               $display("FAIL rel_release got valid %b code %0d rel %b want 1 15 1", key_valid, key_code, key_release);
            else n_pass++;
         end
`endif
      end
`ifdef KEYPAD_RELEASE_EVENT_EN
      n_checks++; if (events !== 2) $display("FAIL rel_count got %0d want 2", events); else n_pass++;
`else
      n_checks++; if (events !== 1) $display("FAIL rel_count got %0d want 1", events); else n_pass++;
`endif
   endtask

   task automatic test_random();
      logic [3:0] rs [4];
      logic [3:0] c;
      logic [3:0] want_down_dummy;
      int         ci;
      do_reset();
      for (int j = 0; j < 4; j++) rs[j] = 4'hF;
      want_down_dummy = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            ci = int'($urandom_range(3));
            rs[ci][$urandom_range(3)] = ~rs[ci][$urandom_range(3)];
         end
         if ($urandom_range(4) == 0) c = 4'($urandom_range(15));
         else c = rot_col(i);
         ci = 0;
         for (int j = 0; j < 4; j++) if (!c[j]) ci = j;
         cyc(c, ($urandom_range(30) == 0) ? 4'($urandom_range(15)) : rs[ci], 1'($urandom_range(2) != 0));
         n_checks++;
         if (key_down !== model_down_vec()) $display("FAIL rand_down cyc %0d got %h want %h", i, key_down, model_down_vec());
         else n_pass++;
         n_checks++;
         if (key_valid !== m_valid) $display("FAIL rand_valid cyc %0d got %b want %b", i, key_valid, m_valid);
         else n_pass++;
         if (m_valid) begin
            n_checks++;
            if (key_code !== m_code || key_release !== m_rel)
               $display("FAIL rand_event cyc %0d got code %0d rel %b want code %0d rel %b", i, key_code, key_release, m_code, m_rel);
            else n_pass++;
         end
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_idle_rotation();
      test_key6_press();
      test_reset_mid_event();
      test_bounce();
      test_back_to_back();
      test_invalid_columns();
      test_release();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
